// File: rtl/data_memory_unit.sv
// ----------------------------------------------------------------------------
// data_memory_unit
//
// Memory-stage data memory plus memory-mapped I/O for the pipelined core.
// Loads are combinational so the MEM/WB pipe register captures rdata on the
// next rising edge. Stores commit on the rising edge when memw is high.
//
// Address map (address[31:16] must be zero, address[1:0] ignored):
//   0x0000-0x0FFF  word RAM, index address[11:2] mod RAM_WORDS
//   0x1000         GPIO output register (R/W)
//   0x1004         write: push into output FIFO
//                  read : status {count[.. :5], overflow[4], full[3], empty[2]}
//   0x1008         free-running cycle counter (R/W), only with
//                  DMEM_CYCLE_COUNTER_EN defined; otherwise unmapped
//   0x100C         write: clear sticky overflow; reads 0
//   anything else  reads 0, writes ignored
//
// Optional feature macro: DMEM_CYCLE_COUNTER_EN
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   memw       store enable
//   address    byte address
//   wdata      store data
//   rdata      combinational load data
//   gpio_out   GPIO output register
//   out_valid  FIFO non-empty
//   out_data   FIFO head word (first-word fall-through, 0 when empty)
//   out_ready  downstream accepts head when out_valid is high
// ----------------------------------------------------------------------------
module data_memory_unit #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memw,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] gpio_out,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int FAW    = $clog2(FIFO_DEPTH);
    localparam int CW     = FAW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // ---------------- address decode ----------------
    logic              w_hi_zero;
    logic [13:0]       w_word;
    logic              w_sel_ram;
    logic              w_sel_gpio;
    logic              w_sel_fifo;
    logic              w_sel_cnt;
    logic              w_sel_ovclr;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_unused_addr;

    assign w_hi_zero   = (address[31:16] == 16'h0000);
    assign w_word      = address[15:2];
    assign w_sel_ram   = w_hi_zero && (address[15:12] == 4'h0);
    assign w_sel_gpio  = w_hi_zero && (w_word == 14'h0400);
    assign w_sel_fifo  = w_hi_zero && (w_word == 14'h0401);
    assign w_sel_cnt   = w_hi_zero && (w_word == 14'h0402);
    assign w_sel_ovclr = w_hi_zero && (w_word == 14'h0403);
    assign w_ram_idx   = address[RAM_AW+1:2];
    // Byte offset within a word is irrelevant for word-only accesses.
    assign w_unused_addr = &{1'b0, address[1:0]};

    // ---------------- RAM (not reset) ----------------
    logic [31:0] r_ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (memw && w_sel_ram) begin
            r_ram[w_ram_idx] <= wdata;
        end
    end

    // ---------------- GPIO ----------------
    logic [31:0] r_gpio;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gpio <= '0;
        end else if (memw && w_sel_gpio) begin
            r_gpio <= wdata;
        end
    end

    assign gpio_out = r_gpio;

    // ---------------- output FIFO ----------------
    logic [31:0]   r_fifo [FIFO_DEPTH];
    logic [FAW-1:0] r_wr_ptr;
    logic [FAW-1:0] r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_overflow;
    logic           w_empty;
    logic           w_full;
    logic           w_pop;
    logic           w_push_req;
    logic           w_push_ok;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == DEPTH_C);
    assign w_pop      = !w_empty && out_ready;
    assign w_push_req = memw && w_sel_fifo;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push_ok  = w_push_req && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + FAW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FAW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push_ok) begin
                r_overflow <= 1'b1;
            end else if (memw && w_sel_ovclr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign out_valid = !w_empty;
    // Head is masked to 0 when empty so reset presents a clean zero without
    // having to clear the storage array.
    assign out_data  = w_empty ? 32'h0 : r_fifo[r_rd_ptr];

    // Count occupies bits [7:5] for small depths and up to [12:5] otherwise;
    // zero-extending from bit 5 satisfies both layouts.
    logic [31:0] w_status;

    always_comb begin
        w_status            = '0;
        w_status[4]         = r_overflow;
        w_status[3]         = w_full;
        w_status[2]         = w_empty;
        w_status[5 +: CW]   = r_count;
    end

    // ---------------- cycle counter ----------------
    logic [31:0] w_cnt_rdata;

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] r_cycle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle <= '0;
        end else if (memw && w_sel_cnt) begin
            r_cycle <= wdata;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    assign w_cnt_rdata = r_cycle;
`else
    assign w_cnt_rdata = 32'h0;
`endif

    // ---------------- load mux ----------------
    always_comb begin
        rdata = 32'h0;
        if (w_sel_ram) begin
            rdata = r_ram[w_ram_idx];
        end else if (w_sel_gpio) begin
            rdata = r_gpio;
        end else if (w_sel_fifo) begin
            rdata = w_status;
        end else if (w_sel_cnt) begin
            rdata = w_cnt_rdata;
        end
    end

endmodule

// File: tb/tb_data_memory_unit.sv
module tb_data_memory_unit;

    logic        clk;
    logic        rst;
    logic        memw;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] gpio_out;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    data_memory_unit #(
        .RAM_WORDS (1024),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .memw     (memw),
        .address  (address),
        .wdata    (wdata),
        .rdata    (rdata),
        .gpio_out (gpio_out),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per cycle: inputs applied after the falling edge; expected
    // values are those seen before the following rising edge.
    typedef struct {
        logic        memw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ready;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [31:0] exp_gpio;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic m, input logic [31:0] a, input logic [31:0] w,
                       input logic r, input logic c, input logic [31:0] er,
                       input logic [31:0] eg, input logic ev, input logic [31:0] ed);
        vec_t v;
        v.memw = m; v.addr = a; v.wdata = w; v.ready = r; v.chk_rd = c;
        v.exp_rd = er; v.exp_gpio = eg; v.exp_valid = ev; v.exp_data = ed;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; memw = 1'b0; address = 32'h1004; wdata = '0; out_ready = 1'b0;

        //   memw addr          wdata         rdy chk rdata         gpio  vld data
        add(1, 32'h0000_0010, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0,  0, 32'h0);  // 0
        add(0, 32'h0000_0010, 32'h0,        0, 1, 32'hDEADBEEF, 32'h0,  0, 32'h0);  // 1
        add(0, 32'h0000_0013, 32'h0,        0, 1, 32'hDEADBEEF, 32'h0,  0, 32'h0);  // 2
        add(0, 32'h0000_2000, 32'h0,        0, 1, 32'h0,        32'h0,  0, 32'h0);  // 3
        add(1, 32'h0001_0010, 32'h12345678, 0, 1, 32'h0,        32'h0,  0, 32'h0);  // 4
        add(0, 32'h0000_0010, 32'h0,        0, 1, 32'hDEADBEEF, 32'h0,  0, 32'h0);  // 5
        add(1, 32'h0000_1000, 32'hA5,       0, 1, 32'h0,        32'h0,  0, 32'h0);  // 6
        add(0, 32'h0000_1000, 32'h0,        0, 1, 32'hA5,       32'hA5, 0, 32'h0);  // 7
        add(0, 32'h0000_100C, 32'h0,        0, 1, 32'h0,        32'hA5, 0, 32'h0);  // 8
        add(0, 32'h0000_1004, 32'h0,        0, 1, 32'h04,       32'hA5, 0, 32'h0);  // 9
        add(1, 32'h0000_1004, 32'd1,        0, 1, 32'h04,       32'hA5, 0, 32'h0);  // 10
        add(1, 32'h0000_1004, 32'd2,        0, 1, 32'h20,       32'hA5, 1, 32'd1);  // 11
        add(1, 32'h0000_1004, 32'd3,        0, 1, 32'h40,       32'hA5, 1, 32'd1);  // 12
        add(1, 32'h0000_1004, 32'd4,        0, 1, 32'h60,       32'hA5, 1, 32'd1);  // 13
        add(1, 32'h0000_1004, 32'd5,        0, 1, 32'h88,       32'hA5, 1, 32'd1);  // 14
        add(0, 32'h0000_1004, 32'h0,        0, 1, 32'h98,       32'hA5, 1, 32'd1);  // 15
        add(0, 32'h0000_1004, 32'h0,        1, 1, 32'h98,       32'hA5, 1, 32'd1);  // 16
        add(0, 32'h0000_1004, 32'h0,        1, 1, 32'h70,       32'hA5, 1, 32'd2);  // 17
        add(0, 32'h0000_1004, 32'h0,        1, 1, 32'h50,       32'hA5, 1, 32'd3);  // 18
        add(0, 32'h0000_1004, 32'h0,        1, 1, 32'h30,       32'hA5, 1, 32'd4);  // 19
        add(0, 32'h0000_1004, 32'h0,        1, 1, 32'h14,       32'hA5, 0, 32'h0);  // 20
        add(1, 32'h0000_1004, 32'd10,       0, 1, 32'h14,       32'hA5, 0, 32'h0);  // 21
        add(1, 32'h0000_1004, 32'd11,       0, 1, 32'h30,       32'hA5, 1, 32'd10); // 22
        add(1, 32'h0000_1004, 32'd12,       0, 1, 32'h50,       32'hA5, 1, 32'd10); // 23
        add(1, 32'h0000_1004, 32'd13,       0, 1, 32'h70,       32'hA5, 1, 32'd10); // 24
        add(1, 32'h0000_1004, 32'd9,        1, 1, 32'h98,       32'hA5, 1, 32'd10); // 25
        add(0, 32'h0000_1004, 32'h0,        0, 1, 32'h98,       32'hA5, 1, 32'd11); // 26
        add(1, 32'h0000_100C, 32'h0,        0, 1, 32'h0,        32'hA5, 1, 32'd11); // 27
        add(0, 32'h0000_1004, 32'h0,        0, 1, 32'h88,       32'hA5, 1, 32'd11); // 28
        add(1, 32'h0000_0020, 32'd7,        0, 0, 32'h0,        32'hA5, 1, 32'd11); // 29
        add(1, 32'h0000_0020, 32'd8,        0, 1, 32'd7,        32'hA5, 1, 32'd11); // 30
        add(0, 32'h0000_0020, 32'h0,        0, 1, 32'd8,        32'hA5, 1, 32'd11); // 31
        add(0, 32'h0000_1004, 32'h0,        1, 1, 32'h88,       32'hA5, 1, 32'd11); // 32
        add(0, 32'h0000_1004, 32'h0,        1, 1, 32'h60,       32'hA5, 1, 32'd12); // 33
        add(0, 32'h0000_1004, 32'h0,        1, 1, 32'h40,       32'hA5, 1, 32'd13); // 34
        add(0, 32'h0000_1004, 32'h0,        1, 1, 32'h20,       32'hA5, 1, 32'd9);  // 35
        add(1, 32'h0000_1004, 32'h55,       1, 1, 32'h04,       32'hA5, 0, 32'h0);  // 36
        add(0, 32'h0000_1004, 32'h0,        0, 1, 32'h20,       32'hA5, 1, 32'h55); // 37

        // Reset state
        @(negedge clk);
        #1;
        check("rst_gpio",   gpio_out, 32'h0);
        check("rst_valid",  {31'h0, out_valid}, 32'h0);
        check("rst_data",   out_data, 32'h0);
        check("rst_status", rdata, 32'h04);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            memw = vecs[i].memw; address = vecs[i].addr;
            wdata = vecs[i].wdata; out_ready = vecs[i].ready;
            #1;
            if (vecs[i].chk_rd)
                check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rd);
            check($sformatf("v%0d_gpio", i),  gpio_out, vecs[i].exp_gpio);
            check($sformatf("v%0d_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].exp_valid});
            check($sformatf("v%0d_data", i),  out_data, vecs[i].exp_data);
        end

        // Asynchronous reset in the middle of a cycle
        @(negedge clk);
        memw = 1'b0; out_ready = 1'b0; address = 32'h1004;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_gpio",   gpio_out, 32'h0);
        check("mid_rst_valid",  {31'h0, out_valid}, 32'h0);
        check("mid_rst_data",   out_data, 32'h0);
        check("mid_rst_status", rdata, 32'h04);
        address = 32'h0000_0010;
        #1;
        check("ram_kept", rdata, 32'hDEADBEEF);

        // Cycle counter from reset release
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        address = 32'h1008;
        #1;
`ifdef DMEM_CYCLE_COUNTER_EN
        check("cnt_10", rdata, 32'd10);
`else
        check("cnt_off_a", rdata, 32'h0);
`endif
        memw = 1'b1; wdata = 32'hFFFF_FFFE;
        @(negedge clk);
        memw = 1'b0; wdata = '0;
        #1;
`ifdef DMEM_CYCLE_COUNTER_EN
        check("cnt_load", rdata, 32'hFFFF_FFFE);
`else
        check("cnt_off_b", rdata, 32'h0);
`endif
        @(negedge clk);
        #1;
`ifdef DMEM_CYCLE_COUNTER_EN
        check("cnt_max", rdata, 32'hFFFF_FFFF);
`else
        check("cnt_off_c", rdata, 32'h0);
`endif
        @(negedge clk);
        #1;
        check("cnt_wrap", rdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
